// File: rtl/alarm_pkg.sv
// Shared types for the alarm sequencer: state encoding and illegal-code recovery target.
// No datapath latency or backpressure; definitions only.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL = 3'd0,
        ST_WARN   = 3'd1,
        ST_ALARM  = 3'd2,
        ST_ACKED  = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam state_t ST_RECOVER = ST_NORMAL;

endpackage

// File: rtl/persist_filter.sv
// Persistence qualifier: q rises once cond has been sampled high PERSIST edges in a row.
// q is valid the cycle after the PERSIST-th edge; no backpressure, any low sample restarts.
module persist_filter #(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cond,
    output logic q
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] CMAX = CW'(PERSIST);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!cond) begin
            cnt <= '0;
        end else if (cnt != CMAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign q = (cnt == CMAX);

endmodule

// File: rtl/alarm_sequencer.sv
// Debounced, latched alarm FSM with operator ack, blink generator and registered lamp/siren outputs.
// Outputs change on the same edge as state; no backpressure, inputs are sampled every edge.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int PERSIST = 4,
    parameter int BLINK   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ok,
    input  logic       danger,
    input  logic       alert,
    input  logic       ack,
    output logic       lamp_green,
    output logic       lamp_amber,
    output logic       lamp_red,
    output logic       siren,
    output logic [2:0] state
);

    localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

    logic q_ok, q_danger, q_alert, q_incons;
    logic incons;

    assign incons = (ok & (danger | alert)) | (~ok & ~danger & ~alert);

    persist_filter #(.PERSIST(PERSIST)) u_q_ok     (.clk(clk), .rst(rst), .cond(ok),     .q(q_ok));
    persist_filter #(.PERSIST(PERSIST)) u_q_danger (.clk(clk), .rst(rst), .cond(danger), .q(q_danger));
    persist_filter #(.PERSIST(PERSIST)) u_q_alert  (.clk(clk), .rst(rst), .cond(alert),  .q(q_alert));
    persist_filter #(.PERSIST(PERSIST)) u_q_incons (.clk(clk), .rst(rst), .cond(incons), .q(q_incons));

    state_t        cur_state, nxt_state;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          phase, phase_nxt;
    logic          green_nxt, amber_nxt, red_nxt, siren_nxt;

    always_comb begin
        nxt_state     = cur_state;
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
        green_nxt     = 1'b0;
        amber_nxt     = 1'b0;
        red_nxt       = 1'b0;
        siren_nxt     = 1'b0;

        case (cur_state)
            ST_NORMAL: begin
                if (q_danger)      nxt_state = ST_ALARM;
                else if (q_incons) nxt_state = ST_FAULT;
                else if (q_alert)  nxt_state = ST_WARN;
            end
            ST_WARN: begin
                if (q_danger)      nxt_state = ST_ALARM;
                else if (q_incons) nxt_state = ST_FAULT;
                else if (q_ok)     nxt_state = ST_NORMAL;
            end
            ST_ALARM: begin
                if (ack) nxt_state = ST_ACKED;
            end
            ST_ACKED: begin
                if (q_ok) nxt_state = ST_NORMAL;
            end
            ST_FAULT: begin
                // A still-qualified inconsistency outranks q_ok, so the fault holds while it persists.
                if (q_danger)                nxt_state = ST_ALARM;
                else if (!q_incons && q_ok)  nxt_state = ST_NORMAL;
            end
            default: nxt_state = ST_RECOVER;
        endcase

        if (nxt_state != cur_state) begin
            blink_cnt_nxt = '0;
            phase_nxt     = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            phase_nxt     = ~phase;
        end else begin
            blink_cnt_nxt = blink_cnt + BW'(1);
        end

        case (nxt_state)
            ST_NORMAL: green_nxt = 1'b1;
            ST_WARN:   amber_nxt = phase_nxt;
            ST_ALARM: begin
                red_nxt   = 1'b1;
                siren_nxt = 1'b1;
            end
            ST_ACKED:  red_nxt = 1'b1;
            ST_FAULT: begin
                amber_nxt = phase_nxt;
                red_nxt   = phase_nxt;
            end
            default:   green_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= ST_NORMAL;
            blink_cnt  <= '0;
            phase      <= 1'b1;
            lamp_green <= 1'b1;
            lamp_amber <= 1'b0;
            lamp_red   <= 1'b0;
            siren      <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            blink_cnt  <= blink_cnt_nxt;
            phase      <= phase_nxt;
            lamp_green <= green_nxt;
            lamp_amber <= amber_nxt;
            lamp_red   <= red_nxt;
            siren      <= siren_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequential back end for the `lamprob` sensor-classification stage. It consumes lamprob's combinational `ok` / `danger` / `alert` flags, debounces them with a persistence filter, and runs a latched alarm state machine with operator acknowledge. It drives the panel lamps and the siren.

## Interface
- `PERSIST`, default 4: consecutive sampled cycles a condition must hold before it is qualified; legal range ≥1.
- `BLINK`, default 8: blink half-period in clock cycles; legal range ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ok`  in  1  from lamprob `ok`.
- `danger`  in  1  from lamprob `danger`.
- `alert`  in  1  from lamprob `alert`.
- `ack`  in  1  operator acknowledge, level-sampled.
- `lamp_green`  out  1  normal indicator.
- `lamp_amber`  out  1  warning/fault indicator.
- `lamp_red`  out  1  alarm indicator.
- `siren`  out  1  audible alarm.
- `state`  out  3  current state encoding, for debug.

## Operation
- **Qualifiers.**
  - There are four saturating counters, width `$clog2(PERSIST+1)`, for these conditions:
    - `ok`
    - `danger`
    - `alert`
    - `incons` = (ok & (danger | alert)) | (~ok & ~danger & ~alert)
  - Each edge: `cnt <= cond ? min(cnt+1, PERSIST) : 0`.
  - `q_x = (cnt_x == PERSIST)`.
- **States:** NORMAL=0, WARN=1, ALARM=2, ACKED=3, FAULT=4. Codes 5–7 are illegal and go to NORMAL on the next edge.
- **Transition priority:** `q_danger` > `q_incons` > `q_alert` > `q_ok`.
- **Transitions by state:**
  - NORMAL:
    - `q_danger` → ALARM.
    - `q_incons` → FAULT.
    - `q_alert` → WARN.
  - WARN:
    - `q_danger` → ALARM.
    - `q_incons` → FAULT.
    - `q_ok` → NORMAL.
  - ALARM: latched and ignores all qualifiers. `ack`=1 → ACKED.
  - ACKED: `q_ok` → NORMAL. There is no other exit; a renewed danger while ACKED does not re-arm the siren.
  - FAULT:
    - `q_danger` → ALARM.
    - `q_ok` → NORMAL.
- `ack` in any state other than ALARM has no effect and is not remembered.
- **Outputs per state:**
  - NORMAL: green=1.
  - WARN: amber=blink.
  - ALARM: red=1, siren=1.
  - ACKED: red=1, siren=0.
  - FAULT: amber=red=blink, in phase.
  - All unlisted outputs are 0.
- **Blink generator.**
  - Counter 0..BLINK-1 plus a phase bit.
  - Both reset to 0 / phase=1 on every state change.
  - Phase toggles when the counter wraps, giving BLINK cycles on, then BLINK cycles off.

## Timing
- **Reset:** `rst`=1 at an edge gives, after that edge:
  - state=NORMAL, all counters 0, phase=1.
  - lamp_green=1, amber=red=siren=0.
  - Reset mid-ALARM clears the latch unconditionally.
- **Registered outputs.** All outputs are registered and decoded from next-state/next-phase, so outputs change on the same edge as `state`.
- **Qualification latency.** A condition high at edges 1..PERSIST sets the qualifier after edge PERSIST. The state and outputs change at edge PERSIST+1.
- A single low sample restarts the count; a glitch shorter than PERSIST never changes state.
- **Ack latency:** `ack` sampled high at edge N in ALARM gives siren=0 after edge N.
- **Simultaneous events.**
  - `q_danger` and `q_incons` in the same cycle → ALARM.
  - `ack` on the same edge that ALARM is entered is ignored, because the state was not yet ALARM when sampled.
- **Blink at entry:** on entering WARN at edge E, amber is 1 for edges E..E+BLINK-1 and 0 for the next BLINK edges.

## Structure
- `alarm_pkg`: 3-bit state enum with the encodings above and the illegal-code recovery constant NORMAL.
- Sub-module `persist_filter` (parameter `PERSIST`; ports `clk`, `rst`, `cond`, `q`), instantiated four times.
- Top level: FSM, blink generator and output register.

## Test plan
- **Reset:** assert `rst` for 2 cycles with danger=1 → green=1, others 0, state=0.
- **Glitch vs. qualify (PERSIST=4):**
  - ok=0, danger=1 for 3 cycles, then ok=1 → no change.
  - danger=1, ok=0 for 4 cycles → after edge 5: state=2, red=1, siren=1.
- **Latch and ack:**
  - In ALARM, return to ok=1 → stays ALARM.
  - ack=1 one cycle → state=3, siren=0, red=1.
  - After 4 ok cycles → NORMAL, green=1.
- **Warn blink (BLINK=8):** ok=0, alert=1 for 4 cycles → WARN. Amber reads 1×8, 0×8, 1×8. ok for 4 cycles → NORMAL.
- **Fault:**
  - ok=1 with alert=1 for 4 cycles → state=4, amber and red blink in phase.
  - danger=1, ok=0 for 4 cycles → ALARM.
- **Mid-alarm reset:** `rst` for one cycle in ALARM → NORMAL next edge, siren=0, counters cleared; a full PERSIST is needed to re-alarm.
